// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, drives the icache
// read port and buffers fetched words with their PCs for decode.
module ifetch_queue #(
  parameter int                 DEPTH    = 4,
  parameter int                 WORD_W   = 32,
  parameter logic [WORD_W-1:0]  PC_RESET = '0,
  parameter int                 PC_STEP  = 4
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         ihit,
  input  logic [WORD_W-1:0]            imemload,
  output logic                         imemREN,
  output logic [WORD_W-1:0]            imemaddr,
  input  logic                         redirect,
  input  logic [WORD_W-1:0]            redirect_pc,
  input  logic                         halt,
  input  logic                         deq_ready,
  output logic                         deq_valid,
  output logic [WORD_W-1:0]            deq_instr,
  output logic [WORD_W-1:0]            deq_pc,
  output logic [WORD_W-1:0]            deq_npc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [WORD_W-1:0] STEP = WORD_W'(PC_STEP);
  localparam logic [PW-1:0]     LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0]     FULL = CW'(DEPTH);

  typedef enum logic {
    FETCH,
    HALTED
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WORD_W-1:0] fetch_pc;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     cnt;
  logic              enq;
  logic              pop;

  logic [WORD_W-1:0] mem_instr [DEPTH];
  logic [WORD_W-1:0] mem_pc    [DEPTH];

  // Circular pointer increment; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Fetch/halt state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= FETCH;
    else       state <= state_nxt;
  end

  // Halt is sticky; only reset leaves HALTED.
  always_comb begin
    state_nxt = state;
    if (state == FETCH && halt) state_nxt = HALTED;
  end

  // Request gated by registered occupancy, so a same-cycle pop frees
  // nothing for this cycle's fetch. Held low while in reset.
  always_comb begin
    imemREN = nRST && (state == FETCH) && (cnt < FULL) && !halt;
    imemaddr = fetch_pc;
    enq = imemREN && ihit && !redirect;
    pop = deq_valid && deq_ready && !redirect;
  end

  // Pointers, occupancy and fetch PC; redirect overrides everything.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_pc <= PC_RESET;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
    end else begin
      if (enq) begin
        wr_ptr   <= ptr_inc(wr_ptr);
        fetch_pc <= fetch_pc + STEP;
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      unique case ({enq, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; contents are only observed through valid slots.
  always_ff @(posedge CLK) begin
    if (enq) begin
      mem_instr[wr_ptr] <= imemload;
      mem_pc[wr_ptr]    <= fetch_pc;
    end
  end

  // Head entry, forced to zero when empty so stale storage never shows.
  always_comb begin
    count     = cnt;
    deq_valid = (cnt != '0);
    deq_instr = '0;
    deq_pc    = '0;
    deq_npc   = '0;
    if (deq_valid) begin
      deq_instr = mem_instr[rd_ptr];
      deq_pc    = mem_pc[rd_ptr];
      deq_npc   = mem_pc[rd_ptr] + STEP;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: per-cycle vector table plus
// hand sequences for reset, halt+redirect and a DEPTH=3 wrap run.
module tb_ifetch_queue;

  logic        CLK = 1'b0;
  logic        nRST;

  logic        ihit, redirect, halt, deq_ready;
  logic [31:0] imemload, redirect_pc;
  logic        imemREN, deq_valid;
  logic [31:0] imemaddr, deq_instr, deq_pc, deq_npc;
  logic [2:0]  count;

  logic        ihit3, rdy3;
  logic [31:0] load3;
  logic        ren3, dv3;
  logic [31:0] addr3, instr3, pc3, npc3;
  logic [1:0]  cnt3;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  ifetch_queue u_dut (
    .CLK(CLK), .nRST(nRST),
    .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .deq_ready(deq_ready),
    .deq_valid(deq_valid), .deq_instr(deq_instr),
    .deq_pc(deq_pc), .deq_npc(deq_npc),
    .count(count)
  );

  assign load3 = addr3 ^ 32'h5A5A_0000;

  ifetch_queue #(.DEPTH(3)) u_d3 (
    .CLK(CLK), .nRST(nRST),
    .ihit(ihit3), .imemload(load3),
    .imemREN(ren3), .imemaddr(addr3),
    .redirect(1'b0), .redirect_pc(32'h0),
    .halt(1'b0), .deq_ready(rdy3),
    .deq_valid(dv3), .deq_instr(instr3),
    .deq_pc(pc3), .deq_npc(npc3),
    .count(cnt3)
  );

  typedef struct {
    logic        ihit;
    logic [31:0] load;
    logic        redir;
    logic [31:0] rpc;
    logic        halt;
    logic        rdy;
    logic        e_ren;
    logic [31:0] e_addr;
    logic        e_dv;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    int          e_cnt;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp,
               $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic ren,
                         input logic [31:0] addr, input logic dv,
                         input logic [31:0] ins, input logic [31:0] pc,
                         input int cnt);
    logic [31:0] npc;
    npc = dv ? pc + 32'd4 : 32'd0;
    chk({tag, ".imemREN"}, 32'(imemREN), 32'(ren));
    chk({tag, ".imemaddr"}, imemaddr, addr);
    chk({tag, ".deq_valid"}, 32'(deq_valid), 32'(dv));
    chk({tag, ".deq_instr"}, deq_instr, ins);
    chk({tag, ".deq_pc"}, deq_pc, pc);
    chk({tag, ".deq_npc"}, deq_npc, npc);
    chk({tag, ".count"}, 32'(count), 32'(cnt));
  endtask

  task automatic idle();
    ihit = 0; imemload = '0; redirect = 0;
    redirect_pc = '0; halt = 0; deq_ready = 0;
  endtask

  initial begin
    // ihit,load,redir,rpc,halt,rdy | ren,addr,dv,instr,pc,cnt
    vecs[0]  = '{1, 32'hA000_0000, 0, 0, 0, 0,
                 1, 32'h0,   0, 32'h0, 32'h0, 0};
    vecs[1]  = '{1, 32'hA000_0004, 0, 0, 0, 0,
                 1, 32'h4,   1, 32'hA000_0000, 32'h0, 1};
    vecs[2]  = '{1, 32'hA000_0008, 0, 0, 0, 0,
                 1, 32'h8,   1, 32'hA000_0000, 32'h0, 2};
    vecs[3]  = '{1, 32'hA000_000C, 0, 0, 0, 0,
                 1, 32'hC,   1, 32'hA000_0000, 32'h0, 3};
    vecs[4]  = '{1, 32'hB000_0000, 0, 0, 0, 0,
                 0, 32'h10,  1, 32'hA000_0000, 32'h0, 4};
    vecs[5]  = '{1, 32'hB000_0000, 0, 0, 0, 1,
                 0, 32'h10,  1, 32'hA000_0000, 32'h0, 4};
    vecs[6]  = '{1, 32'hDEAD_0000, 1, 32'h100, 0, 1,
                 1, 32'h10,  1, 32'hA000_0004, 32'h4, 3};
    vecs[7]  = '{0, 32'h0, 0, 0, 0, 0,
                 1, 32'h100, 0, 32'h0, 32'h0, 0};
    vecs[8]  = '{0, 32'h0, 0, 0, 0, 0,
                 1, 32'h100, 0, 32'h0, 32'h0, 0};
    vecs[9]  = '{0, 32'h0, 0, 0, 0, 0,
                 1, 32'h100, 0, 32'h0, 32'h0, 0};
    vecs[10] = '{1, 32'hC000_0100, 0, 0, 0, 0,
                 1, 32'h100, 0, 32'h0, 32'h0, 0};
    vecs[11] = '{1, 32'hC000_0104, 0, 0, 0, 0,
                 1, 32'h104, 1, 32'hC000_0100, 32'h100, 1};
    vecs[12] = '{1, 32'hC000_0108, 0, 0, 1, 0,
                 0, 32'h108, 1, 32'hC000_0100, 32'h100, 2};
    vecs[13] = '{1, 32'hC000_0108, 0, 0, 0, 1,
                 0, 32'h108, 1, 32'hC000_0100, 32'h100, 2};
    vecs[14] = '{0, 32'h0, 0, 0, 0, 1,
                 0, 32'h108, 1, 32'hC000_0104, 32'h104, 1};
    vecs[15] = '{0, 32'h0, 1, 32'h40, 0, 0,
                 0, 32'h108, 0, 32'h0, 32'h0, 0};
    vecs[16] = '{0, 32'h0, 0, 0, 0, 0,
                 0, 32'h40,  0, 32'h0, 32'h0, 0};

    nRST = 0; idle(); ihit3 = 0; rdy3 = 0;
    #1;
    chk_all("reset", 0, 32'h0, 0, 32'h0, 32'h0, 0);

    @(negedge CLK);
    nRST = 1;
    for (int i = 0; i < 17; i++) begin
      ihit = vecs[i].ihit; imemload = vecs[i].load;
      redirect = vecs[i].redir; redirect_pc = vecs[i].rpc;
      halt = vecs[i].halt; deq_ready = vecs[i].rdy;
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_ren, vecs[i].e_addr,
              vecs[i].e_dv, vecs[i].e_instr, vecs[i].e_pc,
              vecs[i].e_cnt);
      @(negedge CLK);
    end

    // Reset out of HALTED, fetch resumes at PC_RESET.
    idle();
    nRST = 0; #1;
    chk_all("rst_halted", 0, 32'h0, 0, 32'h0, 32'h0, 0);
    nRST = 1; #1;
    chk_all("rst_resume", 1, 32'h0, 0, 32'h0, 32'h0, 0);
    @(negedge CLK);
    ihit = 1; imemload = 32'h11;
    @(negedge CLK);
    ihit = 1; imemload = 32'h22;
    @(negedge CLK);
    idle(); #1;
    chk_all("refill", 1, 32'h8, 1, 32'h11, 32'h0, 2);

    // Async reset mid-cycle with entries held.
    nRST = 0; #1;
    chk_all("rst_async", 0, 32'h0, 0, 32'h0, 32'h0, 0);
    nRST = 1;
    @(negedge CLK);

    // Halt and redirect in the same cycle with one entry queued.
    ihit = 1; imemload = 32'h33;
    @(negedge CLK);
    idle(); halt = 1; redirect = 1; redirect_pc = 32'h200;
    ihit = 1; imemload = 32'h44;
    @(negedge CLK);
    idle(); ihit = 1; imemload = 32'h55; #1;
    chk_all("halt_redir", 0, 32'h200, 0, 32'h0, 32'h0, 0);
    @(negedge CLK);
    idle(); #1;
    chk_all("halt_stuck", 0, 32'h200, 0, 32'h0, 32'h0, 0);

    // DEPTH=3 wrap run with random decode back-pressure.
    nRST = 0; #1; nRST = 1;
    begin
      logic [31:0] exp_pc;
      int popped;
      int cyc;
      exp_pc = 0; popped = 0; cyc = 0;
      @(negedge CLK);
      while (popped < 10 && cyc < 300) begin
        ihit3 = 1;
        rdy3 = 1'($urandom_range(0, 1));
        #1;
        if (cnt3 > 2'd3 || (cnt3 == 2'd3 && ren3)) begin
          errors++;
          $display("FAIL d3.full: count %0d imemREN %0b", cnt3, ren3);
        end
        if (dv3 && rdy3) begin
          chk($sformatf("d3.pc%0d", popped), pc3, exp_pc);
          chk($sformatf("d3.ins%0d", popped), instr3,
              exp_pc ^ 32'h5A5A_0000);
          chk($sformatf("d3.npc%0d", popped), npc3, exp_pc + 32'd4);
          exp_pc += 32'd4;
          popped++;
        end
        @(negedge CLK);
        cyc++;
      end
      checks++;
      if (popped != 10) begin
        errors++;
        $display("FAIL d3.timeout: popped %0d required 10", popped);
      end
      ihit3 = 0; rdy3 = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
